// File: rtl/ringbuffer_hex_drain.sv
// Ring buffer hex drain: pops one DW-bit record when the buffer is non-empty,
// then streams it to a UART transmitter as uppercase ASCII hex, MSB nibble
// first, followed by a line terminator. The bytes go out over a valid/ready
// handshake.
// Optional macro RINGBUFFER_HEX_DRAIN_CRLF_EN: terminator is CR LF instead of LF.
module ringbuffer_hex_drain #(
  parameter int unsigned DW = 48,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          empty,
  input  logic [DW-1:0] read_data,
  output logic          read_clock_enable,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic [CW-1:0] record_count
);

  localparam int unsigned Nibbles = DW / 4;
  localparam int unsigned NW      = (Nibbles > 1) ? $clog2(Nibbles) : 1;
  localparam logic [NW-1:0] NibMax = NW'(Nibbles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHex,
`ifdef RINGBUFFER_HEX_DRAIN_CRLF_EN
    StCr,
`endif
    StLf
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          rce_q, rce_d;
  logic [7:0]    txd_q, txd_d;
  logic          txv_q, txv_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] shift_next;
  logic          hs;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Next-state and registered-output values; every state sends one byte per handshake.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rce_d      = 1'b0;
    txd_d      = txd_q;
    txv_d      = txv_q;
    count_d    = count_q;
    hs         = txv_q & tx_ready;
    shift_next = shift_q << 4;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shift_d = read_data;
          cnt_d   = NibMax;
          rce_d   = 1'b1;
          txv_d   = 1'b1;
          txd_d   = hex_ascii(read_data[DW-1 -: 4]);
          state_d = StHex;
        end
      end
      StHex: begin
        if (hs) begin
          shift_d = shift_next;
          if (cnt_q == '0) begin
`ifdef RINGBUFFER_HEX_DRAIN_CRLF_EN
            txd_d   = 8'h0D;
            state_d = StCr;
`else
            txd_d   = 8'h0A;
            state_d = StLf;
`endif
          end else begin
            cnt_d = cnt_q - NW'(1);
            txd_d = hex_ascii(shift_next[DW-1 -: 4]);
          end
        end
      end
`ifdef RINGBUFFER_HEX_DRAIN_CRLF_EN
      StCr: begin
        if (hs) begin
          txd_d   = 8'h0A;
          state_d = StLf;
        end
      end
`endif
      StLf: begin
        if (hs) begin
          txv_d   = 1'b0;
          txd_d   = 8'h00;
          count_d = count_q + CW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset discards any record in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      rce_q   <= 1'b0;
      txd_q   <= 8'h00;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rce_q   <= rce_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign read_clock_enable = rce_q;
  assign tx_data           = txd_q;
  assign tx_valid          = txv_q;
  assign busy              = busy_q;
  assign record_count      = count_q;

endmodule

// File: tb/tb_ringbuffer_hex_drain.sv
// Scoreboard bench for ringbuffer_hex_drain: a queue-based ring buffer model
// feeds records, expected ASCII bytes are queued on push, and a monitor pops
// and compares on every handshake.
module tb_ringbuffer_hex_drain;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        empty = 1'b1;
  logic [47:0] read_data = '0;
  logic        read_clock_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] record_count;

  ringbuffer_hex_drain #(.DW(48), .CW(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .empty             (empty),
    .read_data         (read_data),
    .read_clock_enable (read_clock_enable),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .record_count      (record_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  logic [47:0] rb[$];
  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          n_recs = 0;
  int          hs_total = 0;
  int          mode = 0;      // 0: ready high, 1: random ready, 2: 5-cycle stall per byte
  int          stall_cnt = 0;
  bit          prev_rce = 0;
  logic [15:0] exp_count = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void update_rb();
    logic [63:0] g;
    empty = (rb.size() == 0);
    g = {$urandom(), $urandom()};
    read_data = empty ? g[47:0] : rb[0];
  endfunction

  // Reference: the record printed as 12 uppercase hex characters plus the terminator.
  function automatic void push_rec(input logic [47:0] r);
    string hc = "0123456789ABCDEF";
    exp_t e;
    logic [3:0] n;
    rb.push_back(r);
    for (int i = 0; i < 12; i++) begin
      n = r[47 - 4 * i -: 4];
      e.b = hc[n];
      e.last = 0;
      expq.push_back(e);
    end
`ifdef RINGBUFFER_HEX_DRAIN_CRLF_EN
    e.b = 8'h0D;
    e.last = 0;
    expq.push_back(e);
`endif
    e.b = 8'h0A;
    e.last = 1;
    expq.push_back(e);
    n_recs++;
    update_rb();
  endfunction

  // One cycle of the ring buffer model and the transmitter, acting on the falling edge.
  task automatic tick();
    @(negedge clock);
    if (reset) begin
      if (read_clock_enable) begin
        chk(rb.size() > 0, "pop_from_empty", 64'(rb.size()), 64'd1);
        if (rb.size() > 0) void'(rb.pop_front());
        pops++;
      end
      if (read_clock_enable && prev_rce) chk(0, "double_pop", 1, 0);
      prev_rce = read_clock_enable;
    end
    case (mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (tx_valid && stall_cnt < 5) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = 1'b1;
          stall_cnt = 0;
        end
      end
    endcase
    update_rb();
  endtask

  task automatic drain();
    int k = 0;
    while ((rb.size() != 0 || expq.size() != 0 || busy) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) chk(0, "drain_timeout", 64'(expq.size()), 0);
    repeat (2) tick();
  endtask

  // Monitor: samples 2 time units after the falling edge, once tx_ready is settled.
  bit         p_v, p_r, p_hs, p_last;
  logic [7:0] p_d;
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      expq.delete();
      exp_count = '0;
      p_v = 0; p_r = 0; p_hs = 0; p_last = 0; p_d = '0;
    end else begin
      exp_t e;
      bit hs;
      chk(record_count == exp_count, "record_count", 64'(record_count), 64'(exp_count));
      chk(busy == tx_valid, "busy_vs_valid", 64'(busy), 64'(tx_valid));
      if (read_clock_enable) chk(tx_valid, "first_byte_latency", 64'(tx_valid), 1);
      if (p_v && !p_r)
        chk(tx_valid && tx_data == p_d, "stall_hold", {tx_valid, tx_data}, {1'b1, p_d});
      if (p_hs && !p_last) chk(tx_valid, "no_bubble", 64'(tx_valid), 1);
      if (p_hs && p_last) chk(!tx_valid, "idle_after_record", 64'(tx_valid), 0);
      hs = tx_valid && tx_ready;
      p_last = 0;
      if (hs) begin
        if (expq.size() == 0) begin
          chk(0, "unexpected_byte", 64'(tx_data), 0);
        end else begin
          e = expq.pop_front();
          chk(tx_data == e.b, "tx_data", 64'(tx_data), 64'(e.b));
          if (e.last) exp_count = exp_count + 16'd1;
          p_last = e.last;
        end
        hs_total++;
      end
      p_v = tx_valid; p_r = tx_ready; p_d = tx_data; p_hs = hs;
    end
  end

  initial begin
    int base, k;
    repeat (3) @(negedge clock);
    chk(read_clock_enable == 0, "reset_rce", 64'(read_clock_enable), 0);
    chk(tx_valid == 0, "reset_tx_valid", 64'(tx_valid), 0);
    chk(tx_data == 0, "reset_tx_data", 64'(tx_data), 0);
    chk(busy == 0, "reset_busy", 64'(busy), 0);
    chk(record_count == 0, "reset_count", 64'(record_count), 0);
    #3 reset = 1'b1;

    // Single record, ready high.
    mode = 0;
    tick();
    push_rec(48'h0123456789AB);
    drain();
    chk(record_count == 16'd1, "single_count", 64'(record_count), 1);
    chk(pops == 1, "single_pops", 64'(pops), 1);
    chk(busy == 0, "single_busy", 64'(busy), 0);

    // Backpressure: 5 stall cycles on every byte.
    mode = 2;
    push_rec(48'hFEDCBA987654);
    drain();
    chk(pops == 2, "stall_pops", 64'(pops), 2);

    // Back-to-back records with the buffer never empty in between.
    mode = 0;
    push_rec(48'h000000000000);
    push_rec(48'hFFFFFFFFFFFF);
    drain();
    chk(pops == 4, "b2b_pops", 64'(pops), 4);
    chk(record_count == 16'(n_recs), "b2b_count", 64'(record_count), 64'(n_recs));

    // Empty buffer stays idle.
    for (int i = 0; i < 100; i++) begin
      tick();
      chk(!read_clock_enable && !tx_valid && !busy, "empty_idle",
          {read_clock_enable, tx_valid, busy}, 0);
    end

    push_rec(48'h00000000000A);
    drain();

    // Random records, random ready, random gaps.
    mode = 1;
    for (int r = 0; r < 30; r++) begin
      push_rec({16'($urandom()), 32'($urandom())});
      k = $urandom_range(0, 20);
      repeat (k) tick();
    end
    drain();
    chk(pops == n_recs, "random_pops", 64'(pops), 64'(n_recs));
    chk(record_count == 16'(n_recs), "random_count", 64'(record_count), 64'(n_recs));

    // Reset after the 5th hex byte handshake.
    mode = 0;
    base = hs_total;
    push_rec(48'h13579BDF2468);
    k = 0;
    while (hs_total < base + 5 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk(0, "reset_wait_timeout", 64'(hs_total - base), 5);
    tick();
    #3 reset = 1'b0;
    #1;
    chk(!tx_valid && !busy && !read_clock_enable, "midreset_outputs",
        {tx_valid, busy, read_clock_enable}, 0);
    chk(record_count == 0, "midreset_count", 64'(record_count), 0);
    rb.delete();
    n_recs = 0;
    tick();
    tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk(!tx_valid && !busy && !read_clock_enable, "post_reset_idle",
          {tx_valid, busy, read_clock_enable}, 0);
    end
    chk(record_count == 0, "post_reset_count", 64'(record_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
